// File: rtl/hc161_chain_seq_pkg.sv
// Shared definitions for the cascaded hc161 timer/divider controller.
package hc161_chain_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2,
        ST_FIN  = 2'd3
    } seq_state_t;

    localparam int         STAGE_W = 4;
    localparam logic [3:0] NIB_MAX = 4'hF;

endpackage

// File: rtl/hc161_chain_seq_hc161.sv
// One hc161-style 4-bit synchronous counter stage: async clear, synchronous
// parallel load, count when ENP and ENT are both high, ripple-carry out.
module hc161_chain_seq_hc161
    import hc161_chain_seq_pkg::*;
(
    input  logic               CLK,
    input  logic               nCLR,
    input  logic               nLOAD,
    input  logic               ENP,
    input  logic               ENT,
    input  logic [STAGE_W-1:0] D,
    output logic [STAGE_W-1:0] Q,
    output logic               RCO
);

    // Counter register: load has priority over counting.
    always_ff @(posedge CLK or negedge nCLR) begin
        if (!nCLR) begin
            Q <= '0;
        end else if (!nLOAD) begin
            Q <= D;
        end else if (ENP && ENT) begin
            Q <= Q + 4'd1;
        end
    end

    assign RCO = ENT && (Q == NIB_MAX);

endmodule

// File: rtl/hc161_chain_seq.sv
// Wide programmable timer/divider built from NSTAGE cascaded hc161 stages.
// The controller only drives nLOAD/ENP/ENT/DATA of the stages; the count
// itself lives in the stages.
// Optional: define HC161_SEQ_TCCNT_EN to add TC_CNT, a saturating count of
// TC strobes since the last accepted START.
//
// state | meaning
// IDLE  | waiting for START, count frozen
// LOAD  | all stages parallel-load the latched reload value
// RUN   | counting; TC at all-ones, reload (periodic) or stop (one-shot)
// FIN   | one-shot complete, DONE strobe, count held at all-ones
module hc161_chain_seq
    import hc161_chain_seq_pkg::*;
#(
    parameter int NSTAGE = 2
)(
    input  logic                        CLK,
    input  logic                        nCLR,
    input  logic                        START,
    input  logic                        ABORT,
    input  logic                        PERIODIC,
    input  logic                        PAUSE,
    input  logic [STAGE_W*NSTAGE-1:0]   RELOAD,
    output logic [STAGE_W*NSTAGE-1:0]   COUNT,
    output logic                        BUSY,
    output logic                        TC,
    output logic                        DONE
`ifdef HC161_SEQ_TCCNT_EN
    ,
    output logic [7:0]                  TC_CNT
`endif
);

    localparam int W = STAGE_W * NSTAGE;

    seq_state_t          state, state_nx;
    logic [W-1:0]        rld_r;
    logic                per_r;
    logic                accept_c;
    logic                tc_c;
    logic                nload_c;
    logic                enp_c;
    logic                all_ones;
    logic [NSTAGE-1:0]   ent;
    logic [NSTAGE-1:0]   rco;

    // The last stage's carry is high only when every stage reads F,
    // i.e. the whole count is all-ones.
    assign all_ones = rco[NSTAGE-1];

    // State register and the START-time snapshot of reload/mode.
    always_ff @(posedge CLK or negedge nCLR) begin
        if (!nCLR) begin
            state <= ST_IDLE;
            rld_r <= '0;
            per_r <= 1'b0;
        end else begin
            state <= state_nx;
            if (accept_c) begin
                rld_r <= RELOAD;
                per_r <= PERIODIC;
            end
        end
    end

    // Next state plus stage control; ABORT suppresses load, count and TC so
    // the count freezes where it is.
    always_comb begin
        state_nx = state;
        accept_c = 1'b0;
        tc_c     = 1'b0;
        nload_c  = 1'b1;
        enp_c    = 1'b0;
        BUSY     = 1'b0;
        DONE     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (START && !ABORT) begin
                    accept_c = 1'b1;
                    state_nx = ST_LOAD;
                end
            end
            ST_LOAD: begin
                BUSY = 1'b1;
                if (ABORT) begin
                    state_nx = ST_IDLE;
                end else begin
                    nload_c  = 1'b0;
                    state_nx = ST_RUN;
                end
            end
            ST_RUN: begin
                BUSY = 1'b1;
                if (ABORT) begin
                    state_nx = ST_IDLE;
                end else if (!PAUSE) begin
                    if (all_ones) begin
                        tc_c = 1'b1;
                        if (per_r) begin
                            nload_c = 1'b0;
                        end else begin
                            state_nx = ST_FIN;
                        end
                    end else begin
                        enp_c = 1'b1;
                    end
                end
            end
            ST_FIN: begin
                DONE     = 1'b1;
                state_nx = ST_IDLE;
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    assign TC     = tc_c;
    assign ent[0] = 1'b1;

    // Counter stages with the ripple-carry enable chain between them.
    for (genvar i = 0; i < NSTAGE; i++) begin : g_stage
        hc161_chain_seq_hc161 u_stage (
            .CLK   (CLK),
            .nCLR  (nCLR),
            .nLOAD (nload_c),
            .ENP   (enp_c),
            .ENT   (ent[i]),
            .D     (rld_r[STAGE_W*i +: STAGE_W]),
            .Q     (COUNT[STAGE_W*i +: STAGE_W]),
            .RCO   (rco[i])
        );
        if (i > 0) begin : g_ent
            assign ent[i] = rco[i-1];
        end
    end

`ifdef HC161_SEQ_TCCNT_EN
    // Saturating TC event counter, restarted by each accepted START.
    always_ff @(posedge CLK or negedge nCLR) begin
        if (!nCLR) begin
            TC_CNT <= '0;
        end else if (accept_c) begin
            TC_CNT <= '0;
        end else if (tc_c && (TC_CNT != 8'hFF)) begin
            TC_CNT <= TC_CNT + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_hc161_chain_seq.sv
// Scoreboard bench for hc161_chain_seq (NSTAGE=2, 8-bit count).
module tb_hc161_chain_seq;

    localparam int P_IDLE = 0;
    localparam int P_LOAD = 1;
    localparam int P_RUN  = 2;
    localparam int P_FIN  = 3;

    logic       CLK = 1'b0;
    logic       nCLR;
    logic       START, ABORT, PERIODIC, PAUSE;
    logic [7:0] RELOAD;
    logic [7:0] COUNT;
    logic       BUSY, TC, DONE;
`ifdef HC161_SEQ_TCCNT_EN
    logic [7:0] TC_CNT;
`endif

    hc161_chain_seq #(.NSTAGE(2)) dut (
        .CLK      (CLK),
        .nCLR     (nCLR),
        .START    (START),
        .ABORT    (ABORT),
        .PERIODIC (PERIODIC),
        .PAUSE    (PAUSE),
        .RELOAD   (RELOAD),
        .COUNT    (COUNT),
        .BUSY     (BUSY),
        .TC       (TC),
        .DONE     (DONE)
`ifdef HC161_SEQ_TCCNT_EN
        ,
        .TC_CNT   (TC_CNT)
`endif
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    typedef struct {
        bit         kind;   // 0 = TC, 1 = DONE
        int         cyc;
        logic [7:0] cnt;
    } ev_t;

    ev_t sb[$];
    int  total = 0;
    int  bad   = 0;

    // reference model: phase, count value, latched reload/mode, TC tally
    int         ph  = P_IDLE;
    logic [7:0] mv  = 8'h00;
    logic [7:0] mrl = 8'h00;
    bit         mper = 1'b0;
    int         mtc = 0;

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Monitor: every strobe must match the head of the scoreboard.
    always @(negedge CLK) begin
        if (nCLR) begin
            if (TC) begin
                total++;
                if (sb.size() > 0 && sb[0].kind == 1'b0 && sb[0].cyc == cyc && COUNT == sb[0].cnt)
                    void'(sb.pop_front());
                else begin
                    bad++;
                    $display("FAIL tc_strobe: TC with COUNT=%0h at cycle %0d not expected here", COUNT, cyc);
                end
            end
            if (DONE) begin
                total++;
                if (sb.size() > 0 && sb[0].kind == 1'b1 && sb[0].cyc == cyc && COUNT == sb[0].cnt)
                    void'(sb.pop_front());
                else begin
                    bad++;
                    $display("FAIL done_strobe: DONE with COUNT=%0h at cycle %0d not expected here", COUNT, cyc);
                end
            end
            while (sb.size() > 0 && sb[0].cyc <= cyc) begin
                total++;
                bad++;
                $display("FAIL missing_strobe: kind=%0d due at cycle %0d, got none", sb[0].kind, sb[0].cyc);
                void'(sb.pop_front());
            end
        end
    end

    // One clock cycle of stimulus; entered and left at posedge+1.
    task automatic step(input bit st, input bit ab, input bit pe, input logic [7:0] rl, input bit pa);
        bit busy_e;
        START = st; ABORT = ab; PERIODIC = pe; RELOAD = rl; PAUSE = pa;
        busy_e = (ph == P_LOAD) || (ph == P_RUN);
        if (ph == P_RUN && mv == 8'hFF && !pa && !ab)
            sb.push_back('{kind: 1'b0, cyc: cyc, cnt: 8'hFF});
        if (ph == P_FIN)
            sb.push_back('{kind: 1'b1, cyc: cyc, cnt: 8'hFF});
        @(negedge CLK);
        chk("count", int'(COUNT), int'(mv));
        chk("busy", int'(BUSY), int'(busy_e));
`ifdef HC161_SEQ_TCCNT_EN
        chk("tc_cnt", int'(TC_CNT), mtc);
`endif
        case (ph)
            P_IDLE: if (st && !ab) begin mrl = rl; mper = pe; mtc = 0; ph = P_LOAD; end
            P_LOAD: if (ab) ph = P_IDLE; else begin mv = mrl; ph = P_RUN; end
            P_RUN: begin
                if (ab) ph = P_IDLE;
                else if (!pa) begin
                    if (mv == 8'hFF) begin
                        if (mtc < 255) mtc++;
                        if (mper) mv = mrl; else ph = P_FIN;
                    end else mv = mv + 8'd1;
                end
            end
            default: ph = P_IDLE;
        endcase
        @(posedge CLK);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) step(0, 0, 0, 8'h00, 0);
    endtask

    initial begin
        int pc;
        bit pa, ab, st, pe;
        logic [7:0] rl;
        nCLR = 1'b0; START = 0; ABORT = 0; PERIODIC = 0; PAUSE = 0; RELOAD = 8'h00;
        repeat (2) @(posedge CLK);
        #1;
        chk("rst_count", int'(COUNT), 0);
        chk("rst_busy", int'(BUSY), 0);
        chk("rst_tc", int'(TC), 0);
        chk("rst_done", int'(DONE), 0);
        nCLR = 1'b1;
        @(posedge CLK); #1;
        idle(2);

        // one-shot from FA: FA..FF, TC at FF, DONE next, count held
        step(1, 0, 0, 8'hFA, 0);
        idle(12);

        // periodic from F0, with an ignored START carrying a new reload
        step(1, 0, 1, 8'hF0, 0);
        idle(20);
        step(1, 0, 0, 8'h80, 0);
        idle(25);
        step(0, 1, 0, 8'h00, 0);
        idle(3);

        // carry across nibbles from 0E all the way to FF
        step(1, 0, 0, 8'h0E, 0);
        idle(250);

        // pause 5 cycles while holding all-ones
        step(1, 0, 0, 8'hFC, 0);
        pc = 0;
        for (int c = 0; c < 30; c++) begin
            pa = (ph == P_RUN && mv == 8'hFF && pc < 5);
            if (pa) pc++;
            step(0, 0, 0, 8'h00, pa);
        end

        // START with ABORT in IDLE does nothing
        step(1, 1, 0, 8'h55, 0);
        idle(2);

        // ABORT at 37: count freezes, no TC/DONE
        step(1, 0, 0, 8'h30, 0);
        for (int c = 0; c < 20; c++) begin
            if (ph == P_RUN && mv == 8'h37) begin
                step(0, 1, 0, 8'h00, 0);
                break;
            end
            step(0, 0, 0, 8'h00, 0);
        end
        idle(3);

        // reload of all-ones, one-shot then periodic
        step(1, 0, 0, 8'hFF, 0);
        idle(5);
        step(1, 0, 1, 8'hFF, 0);
        idle(6);
        step(0, 1, 0, 8'h00, 0);
        idle(2);

        // randomized runs with pauses, aborts and stray STARTs
        for (int t = 0; t < 12; t++) begin
            rl = 8'($urandom_range(150, 255));
            pe = 1'($urandom_range(0, 1));
            step(1, 0, pe, rl, 0);
            for (int c = 0; c < 400 && ph != P_IDLE; c++) begin
                pa = ($urandom_range(0, 7) == 0);
                ab = (c >= 80) || ($urandom_range(0, 199) == 0);
                st = ($urandom_range(0, 15) == 0);
                step(st, ab, ~pe, 8'($urandom), pa);
            end
            idle(1);
        end

        // asynchronous reset in the middle of a run
        step(1, 0, 0, 8'h20, 0);
        idle(10);
        nCLR = 1'b0;
        #1;
        chk("midrst_count", int'(COUNT), 0);
        chk("midrst_busy", int'(BUSY), 0);
        chk("midrst_tc", int'(TC), 0);
        chk("midrst_done", int'(DONE), 0);
        ph = P_IDLE; mv = 8'h00; mrl = 8'h00; mper = 1'b0; mtc = 0;
        sb.delete();
        @(posedge CLK); #1;
        nCLR = 1'b1;
        @(posedge CLK); #1;
        idle(3);

        chk("sb_empty", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/hc161_chain_seq.md
Name: hc161_chain_seq

Overview:
- Controller that cascades NSTAGE hc161 4-bit counter stages into one wide programmable timer/divider.
- Generates per-stage nLOAD/ENP/ENT sequencing, the ripple-carry enable chain and terminal-count handling.
- Supports one-shot and periodic (auto-reload) operation under a START/ABORT command interface.
- Used wherever the design needs a wide divider or interval timer built from the existing counter stage.

Parameters:
- NSTAGE, 2, number of cascaded 4-bit stages; total count width W = 4*NSTAGE; legal range 1..8.

Ports:
- CLK  in  1  clock, all state changes on rising edge.
- nCLR  in  1  asynchronous active-low reset; also drives nCLR of every stage.
- START  in  1  start request, sampled only in IDLE.
- ABORT  in  1  stop request; wins over START.
- PERIODIC  in  1  1 = auto-reload at terminal count, 0 = one-shot; sampled with START.
- PAUSE  in  1  level; holds the count while RUN.
- RELOAD  in  W  preload value; sampled with START.
- COUNT  out  W  concatenated stage Q outputs; stage 0 is least significant.
- BUSY  out  1  high in LOAD and RUN.
- TC  out  1  one-cycle terminal-count strobe.
- DONE  out  1  one-cycle completion strobe (one-shot only).

Behaviour:
- Reset (nCLR=0, asynchronous): state IDLE, COUNT=0, BUSY=0, TC=0, DONE=0, latched RELOAD/PERIODIC = 0.
- States: IDLE, LOAD, RUN, FIN.
- IDLE:
  - START=1 and ABORT=0 -> latch RELOAD into rld_r and PERIODIC into per_r; go to LOAD.
  - Otherwise stay. COUNT holds; all ENP=0, nLOAD=1.
- LOAD: all stage nLOAD=0 for exactly one cycle. COUNT=rld_r after the edge; go to RUN.
- RUN enable chain:
  - ENP (all stages) = !PAUSE.
  - ENT[0] = 1; ENT[i] = ENT[i-1] & (Q[i-1]==4'hF).
- Terminal condition tc_c = RUN & (COUNT == all-ones) & !PAUSE. TC = tc_c (combinational strobe, one cycle per event).
- At tc_c with per_r=1:
  - Assert nLOAD to all stages in the same cycle, so the next COUNT is rld_r, not 0.
  - Stay in RUN.
  - Period is 2^W - rld_r cycles.
- At tc_c with per_r=0:
  - Force ENP=0, so COUNT holds at all-ones.
  - Go to FIN.
- FIN: DONE=1 for one cycle; then IDLE. COUNT stays all-ones.
- Latency: START accepted at edge k -> BUSY=1 and LOAD after k; COUNT=rld_r after k+1.
- PAUSE:
  - Holds COUNT, with no TC and no reload.
  - Resuming at all-ones fires TC in the first unpaused cycle.
- ABORT in LOAD or RUN: next edge -> IDLE, COUNT frozen at current value, no TC/DONE. ABORT in FIN has no effect.
- START while BUSY: ignored. rld_r/per_r are not updated mid-run.
- rld_r = all-ones:
  - one-shot: TC in the first RUN cycle.
  - periodic: TC every cycle.
- nCLR mid-operation: immediate return to reset values; no DONE.

Optional Feature:
- Macro HC161_SEQ_TCCNT_EN.
- Defined:
  - Adds output TC_CNT[7:0], a saturating count of TC strobes since the last accepted START.
  - TC_CNT clears on START acceptance and on nCLR; holds at 8'hFF.
- Undefined: port and logic absent; behaviour otherwise identical.

Decomposition:
- Shared package: state enum (IDLE, LOAD, RUN, FIN), STAGE_W=4, NIB_MAX=4'hF.
- Sub-module: the existing hc161 stage, instantiated NSTAGE times via generate. The controller only drives nLOAD/ENP/ENT/DATA, with no duplicate counter logic.

Test Plan:
- NSTAGE=2, RELOAD=8'hFA, PERIODIC=0, START pulse -> COUNT FA,FB..FF; TC high 1 cycle at FF; DONE next cycle; then IDLE with COUNT=FF and BUSY low.
- RELOAD=8'hF0, PERIODIC=1 -> TC every 16 cycles; COUNT sequence FF->F0, never 00; BUSY stays 1.
- RELOAD=8'h0E, run through 0F->10 -> stage 1 increments only when stage 0 = F (ENT chain); no double step.
- PAUSE high 5 cycles while COUNT=8'hFF -> COUNT holds, no TC; TC fires in the first cycle after PAUSE drops.
- START and ABORT together in IDLE -> no state change. ABORT at COUNT=8'h37 -> IDLE next edge, COUNT=37, no DONE.
- nCLR low mid-RUN -> COUNT=0, BUSY/TC/DONE=0 immediately. A second START during RUN with a new RELOAD -> ignored, period unchanged.
